// File: rtl/data_sync_pkg.sv
// Shared constants for the multi-channel enable-qualified data synchroniser.
// Optional drop counters are enabled with DATA_SYNC_DROP_CNT_EN.
package data_sync_pkg;
   localparam int EN_MODE_LEVEL  = 0;
   localparam int EN_MODE_TOGGLE = 1;
   localparam int MAX_STAGES     = 4;
   localparam int DROP_CNT_W     = 8;
   localparam int WARM_W         = $clog2(MAX_STAGES + 2);
endpackage

// File: rtl/data_sync_ch.sv
// One channel: enable sync chain, edge detect, capture register with valid/ready, toggle ack, sticky ovf.
// Capture lands NUM_STAGES+1 edges after the enable launches; events meeting an unconsumed word are dropped (DATA_SYNC_DROP_CNT_EN adds a drop counter).
module data_sync_ch
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int DATA_WIDTH = 8,
   parameter int EN_MODE    = EN_MODE_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] unsync_dat,
   input  logic                  bus_enable,
   output logic [DATA_WIDTH-1:0] sync_dat,
   output logic                  sync_vld,
   input  logic                  sync_rdy,
   output logic                  enable_pulse,
   output logic                  src_ack,
   output logic                  ovf,
   input  logic                  ovf_clr
`ifdef DATA_SYNC_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   logic [NUM_STAGES-1:0] sync_q, sync_d;
   logic                  prev_q, prev_d;
   logic [WARM_W-1:0]     warm_q, warm_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  vld_q, vld_d;
   logic                  pulse_q, pulse_d;
   logic                  ack_q, ack_d;
   logic                  ovf_q, ovf_d;
   logic                  last_stage, evt, consume, drop;

   always_comb begin
      sync_d     = {sync_q[NUM_STAGES-2:0], bus_enable};
      last_stage = sync_q[NUM_STAGES-1];
      prev_d     = last_stage;
      warm_d     = (warm_q != '0) ? warm_q - WARM_W'(1) : warm_q;
      // Toggle mode blanks events until the chain has flushed the pre-reset level.
      if (EN_MODE == EN_MODE_TOGGLE) begin
         evt = (last_stage ^ prev_q) & (warm_q == '0);
      end else begin
         evt = last_stage & ~prev_q;
      end
      consume = vld_q & sync_rdy;
      drop    = evt & vld_q & ~sync_rdy;
      data_d  = data_q;
      vld_d   = vld_q;
      pulse_d = 1'b0;
      ack_d   = ack_q;
      if (evt && !drop) begin
         data_d  = unsync_dat;
         vld_d   = 1'b1;
         pulse_d = 1'b1;
         ack_d   = ~ack_q;
      end else if (consume) begin
         vld_d = 1'b0;
      end
      ovf_d = (ovf_q & ~ovf_clr) | drop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         warm_q  <= WARM_W'(NUM_STAGES + 1);
         data_q  <= '0;
         vld_q   <= 1'b0;
         pulse_q <= 1'b0;
         ack_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         warm_q  <= warm_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         pulse_q <= pulse_d;
         ack_q   <= ack_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sync_dat     = data_q;
   assign sync_vld     = vld_q;
   assign enable_pulse = pulse_q;
   assign src_ack      = ack_q;
   assign ovf          = ovf_q;

`ifdef DATA_SYNC_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = ovf_clr ? '0 : cnt_q;
      if (drop && (cnt_d != '1)) begin
         cnt_d = cnt_d + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign drop_cnt = cnt_q;
`endif

endmodule

// File: rtl/data_sync_mc.sv
// NUM_CH independent enable-qualified bus synchronisers; capture NUM_STAGES+1 edges after enable, valid held until ready.
// Events arriving while a word is unconsumed set ovf and are dropped; DATA_SYNC_DROP_CNT_EN adds per-channel drop counters.
module data_sync_mc
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int EN_MODE    = EN_MODE_LEVEL
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
   input  logic [NUM_CH-1:0]            bus_enable,
   output logic [NUM_CH*DATA_WIDTH-1:0] sync_bus,
   output logic [NUM_CH-1:0]            sync_valid,
   input  logic [NUM_CH-1:0]            sync_ready,
   output logic [NUM_CH-1:0]            enable_pulse,
   output logic [NUM_CH-1:0]            src_ack,
   output logic [NUM_CH-1:0]            ovf,
   input  logic [NUM_CH-1:0]            ovf_clr
`ifdef DATA_SYNC_DROP_CNT_EN
   ,
   output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
`endif
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      data_sync_ch #(
         .NUM_STAGES (NUM_STAGES),
         .DATA_WIDTH (DATA_WIDTH),
         .EN_MODE    (EN_MODE)
      ) u_ch (
         .clk          (CLK),
         .rst_n        (RST),
         .unsync_dat   (unsync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
         .bus_enable   (bus_enable[c]),
         .sync_dat     (sync_bus[c*DATA_WIDTH +: DATA_WIDTH]),
         .sync_vld     (sync_valid[c]),
         .sync_rdy     (sync_ready[c]),
         .enable_pulse (enable_pulse[c]),
         .src_ack      (src_ack[c]),
         .ovf          (ovf[c]),
         .ovf_clr      (ovf_clr[c])
`ifdef DATA_SYNC_DROP_CNT_EN
         ,
         .drop_cnt     (drop_cnt[c*DROP_CNT_W +: DROP_CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_data_sync_mc.sv
// Scoreboard bench for data_sync_mc: directed scenarios then randomized traffic against an event-schedule model.
// A second instance in toggle mode covers warm-up blanking with the enable high across reset.
module tb_data_sync_mc;
   localparam int NS = 2;
   localparam int DW = 8;
   localparam int NC = 4;

   typedef struct {
      int         ch;
      int         edge_n;
      logic [7:0] w;
   } arr_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic [NC*DW-1:0] unsync_bus = '0;
   logic [NC-1:0]    bus_enable = '0;
   logic [NC-1:0]    sync_ready = '0;
   logic [NC-1:0]    ovf_clr    = '0;
   wire  [NC*DW-1:0] sync_bus;
   wire  [NC-1:0]    sync_valid, enable_pulse, src_ack, ovf;

   logic [7:0] t_bus   = 8'h00;
   logic       t_en    = 1'b1;
   logic       t_ready = 1'b0;
   logic       t_clr   = 1'b0;
   wire  [7:0] t_sync_bus;
   wire        t_valid, t_pulse, t_ack, t_ovf;
`ifdef DATA_SYNC_DROP_CNT_EN
   wire [NC*8-1:0] drop_cnt;
   wire [7:0]      t_drop_cnt;
`endif

   data_sync_mc #(.NUM_STAGES(NS), .DATA_WIDTH(DW), .NUM_CH(NC), .EN_MODE(0)) dut (
      .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
      .sync_bus(sync_bus), .sync_valid(sync_valid), .sync_ready(sync_ready),
      .enable_pulse(enable_pulse), .src_ack(src_ack), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef DATA_SYNC_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   data_sync_mc #(.NUM_STAGES(NS), .DATA_WIDTH(8), .NUM_CH(1), .EN_MODE(1)) dut_t (
      .CLK(CLK), .RST(RST), .unsync_bus(t_bus), .bus_enable(t_en),
      .sync_bus(t_sync_bus), .sync_valid(t_valid), .sync_ready(t_ready),
      .enable_pulse(t_pulse), .src_ack(t_ack), .ovf(t_ovf), .ovf_clr(t_clr)
`ifdef DATA_SYNC_DROP_CNT_EN
      , .drop_cnt(t_drop_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_pulses = 0;
   int last_l[NC];

   bit         m_held[NC];
   bit         m_ack[NC];
   bit         m_ovf[NC];
   bit         m_pulse[NC];
   int         m_cnt[NC];
   logic [7:0] m_word[NC];
   logic [7:0] exp_q[NC][$];
   arr_t       arr_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each launch becomes an event NS+1 edges later; the handshake rules decide its fate.
   always @(posedge CLK) begin : model
      bit         hit[NC];
      logic [7:0] hw[NC];
      bit         consume, drop;
      cyc = cyc + 1;
      for (int c = 0; c < NC; c++) begin
         hit[c] = 1'b0;
         hw[c]  = 8'h00;
         m_pulse[c] = 1'b0;
      end
      if (!RST) begin
         for (int c = 0; c < NC; c++) begin
            m_held[c] = 1'b0; m_ack[c] = 1'b0; m_ovf[c] = 1'b0;
            m_cnt[c] = 0; m_word[c] = 8'h00;
            exp_q[c].delete();
         end
         arr_q.delete();
      end else begin
         while (arr_q.size() > 0 && arr_q[0].edge_n <= cyc) begin
            hit[arr_q[0].ch] = 1'b1;
            hw[arr_q[0].ch]  = arr_q[0].w;
            void'(arr_q.pop_front());
         end
         for (int c = 0; c < NC; c++) begin
            consume = m_held[c] && sync_ready[c];
            drop    = 1'b0;
            if (hit[c] && (!m_held[c] || consume)) begin
               m_held[c]  = 1'b1;
               m_word[c]  = hw[c];
               m_ack[c]   = !m_ack[c];
               m_pulse[c] = 1'b1;
               exp_q[c].push_back(hw[c]);
            end else if (hit[c]) begin
               drop = 1'b1;
            end else if (consume) begin
               m_held[c] = 1'b0;
            end
            if (ovf_clr[c]) begin
               m_ovf[c] = 1'b0;
               m_cnt[c] = 0;
            end
            if (drop) begin
               m_ovf[c] = 1'b1;
               if (m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
            end
         end
      end
   end

   always @(negedge CLK) begin : monitor
      logic [7:0] e;
      if (cyc > 0) begin
         for (int c = 0; c < NC; c++) begin
            if (enable_pulse[c] === 1'b1) begin
               if (exp_q[c].size() == 0) begin
                  checks++; errors++;
                  $display("FAIL capture ch%0d: got unexpected capture %0h required none", c, sync_bus[c*DW +: DW]);
               end else begin
                  e = exp_q[c].pop_front();
                  chk($sformatf("capture word ch%0d", c), 32'(sync_bus[c*DW +: DW]), 32'(e));
               end
            end
            chk($sformatf("enable_pulse ch%0d", c), 32'(enable_pulse[c]), 32'(m_pulse[c]));
            chk($sformatf("sync_valid ch%0d", c), 32'(sync_valid[c]), 32'(m_held[c]));
            chk($sformatf("src_ack ch%0d", c), 32'(src_ack[c]), 32'(m_ack[c]));
            chk($sformatf("ovf ch%0d", c), 32'(ovf[c]), 32'(m_ovf[c]));
            chk($sformatf("sync_bus ch%0d", c), 32'(sync_bus[c*DW +: DW]), 32'(m_word[c]));
`ifdef DATA_SYNC_DROP_CNT_EN
            chk($sformatf("drop_cnt ch%0d", c), 32'(drop_cnt[c*8 +: 8]), 32'(m_cnt[c]));
`endif
         end
      end
      if (t_pulse === 1'b1) t_pulses++;
   end

   task automatic step(input logic [NC-1:0] lm, input logic [NC-1:0] rdy,
                       input logic [NC-1:0] clr, input logic [NC*DW-1:0] words);
      arr_t a;
      for (int c = 0; c < NC; c++) begin
         if (lm[c]) begin
            unsync_bus[c*DW +: DW] = words[c*DW +: DW];
            a.ch = c; a.edge_n = cyc + NS + 1; a.w = words[c*DW +: DW];
            arr_q.push_back(a);
            last_l[c] = cyc;
         end
      end
      bus_enable = lm;
      sync_ready = rdy;
      ovf_clr    = clr;
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input logic [NC-1:0] rdy);
      repeat (n) step('0, rdy, '0, '0);
   endtask

   initial begin
      logic [NC-1:0]    lm, rdy, clr;
      logic [NC*DW-1:0] words;
      for (int c = 0; c < NC; c++) last_l[c] = -100;
      repeat (3) @(negedge CLK);
      RST = 1'b1;

      // toggle-mode instance: enable already 1 through reset must not fire
      idle(10, '0);
      chk("toggle warm-up pulses", 32'(t_pulses), 0);
      chk("toggle warm-up valid", 32'(t_valid), 0);
      t_bus = 8'h5A;
      t_en  = 1'b0;
      idle(8, '0);
      chk("toggle capture count", 32'(t_pulses), 1);
      chk("toggle capture word", 32'(t_sync_bus), 32'h5A);
      chk("toggle valid", 32'(t_valid), 1);
      chk("toggle ack", 32'(t_ack), 1);

      // single capture, latency NS+1
      step(4'b0001, '0, '0, 32'h0000_002D);
      idle(1, '0);
      chk("pulse before edge 3", 32'(enable_pulse), 0);
      idle(1, '0);
      chk("pulse at edge 3", 32'(enable_pulse), 32'h1);
      idle(4, '0);
      chk("held word 2D", 32'(sync_bus[7:0]), 32'h2D);
      chk("held valid", 32'(sync_valid[0]), 1);
      chk("ack after first", 32'(src_ack[0]), 1);

      // handshake and recapture
      step('0, 4'b0001, '0, '0);
      idle(2, '0);
      chk("valid after accept", 32'(sync_valid[0]), 0);
      step(4'b0001, '0, '0, 32'h0000_00DB);
      idle(6, '0);
      chk("recapture DB", 32'(sync_bus[7:0]), 32'hDB);
      chk("ack back to 0", 32'(src_ack[0]), 0);
      step('0, 4'b0001, '0, '0);
      idle(1, '0);

      // overflow
      step(4'b0001, '0, '0, 32'h0000_0011);
      idle(6, '0);
      step(4'b0001, '0, '0, 32'h0000_0022);
      idle(6, '0);
      chk("overflow keeps 11", 32'(sync_bus[7:0]), 32'h11);
      chk("ovf set", 32'(ovf[0]), 1);
`ifdef DATA_SYNC_DROP_CNT_EN
      chk("drop_cnt one", 32'(drop_cnt[7:0]), 1);
`endif
      step('0, '0, 4'b0001, '0);
      chk("ovf cleared", 32'(ovf[0]), 0);
      step('0, 4'b0001, '0, '0);
      idle(1, '0);

      // simultaneous events
      step(4'b1111, '0, '0, 32'hA3A2_A1A0);
      idle(1, '0);
      idle(1, '0);
      chk("all pulses together", 32'(enable_pulse), 32'hF);
      chk("all words", sync_bus, 32'hA3A2_A1A0);
      idle(3, '0);
      step('0, 4'b1111, '0, '0);
      idle(1, '0);

      // reset while a word is held
      step(4'b0010, '0, '0, 32'h0000_7700);
      idle(6, '0);
      chk("held before reset", 32'(sync_valid[1]), 1);
      RST = 1'b0;
      step('0, '0, '0, '0);
      chk("reset sync_bus", sync_bus, 0);
      chk("reset valid", 32'(sync_valid), 0);
      chk("reset pulse", 32'(enable_pulse), 0);
      chk("reset ack", 32'(src_ack), 0);
      chk("reset ovf", 32'(ovf), 0);
      RST = 1'b1;
      idle(8, '0);
      chk("no valid after reset", 32'(sync_valid), 0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         lm = '0;
         for (int c = 0; c < NC; c++) begin
            if ((cyc - last_l[c] >= 6) && ($urandom_range(0, 3) == 0)) lm[c] = 1'b1;
         end
         words = $urandom;
         rdy   = 4'($urandom_range(0, 15));
         clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         step(lm, rdy, clr, words);
      end
      idle(10, 4'b1111);
      chk("pending events drained", 32'(arr_q.size()), 0);
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("unmatched captures ch%0d", c), 32'(exp_q[c].size()), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
